// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback serializer.
// XLEN normally comes from sys_defs.svh; it falls back to 32 when no definition is in scope.
`ifndef XLEN
`define XLEN 32
`endif

package wb_pkg;
    localparam int WB_XLEN  = `XLEN;
    localparam int WB_DEPTH = 4;
    localparam int WB_PTR_W = $clog2(WB_DEPTH);

    typedef struct packed {
        logic [4:0]         idx;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_pending_lookup.sv
// One pending-value lookup port: returns the youngest queued or in-flight value for idx.
import wb_pkg::*;

module wb_pending_lookup #(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [4:0]               idx,
    input  wb_entry_t [DEPTH-1:0]    q,
    input  logic [PTR_W-1:0]         head,
    input  logic [PTR_W:0]           count,
    input  logic                     acc0,
    input  wb_entry_t                in0,
    input  logic                     acc1,
    input  wb_entry_t                in1,
    output logic                     hit,
    output logic [WB_XLEN-1:0]       data
);
    logic [PTR_W-1:0] pos;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        pos  = head;
        // Walk oldest to youngest so the last match seen is the youngest one.
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if ((PTR_W+1)'(k) < count && q[pos].idx == idx) begin
                hit  = 1'b1;
                data = q[pos].data;
            end
        end
        if (acc0 && in0.idx == idx) begin
            hit  = 1'b1;
            data = in0.data;
        end
        if (acc1 && in1.idx == idx) begin
            hit  = 1'b1;
            data = in1.data;
        end
        if (idx == 5'd0) begin
            hit  = 1'b0;
            data = '0;
        end
    end
endmodule

// File: rtl/wb_write_serializer.sv
// Two-lane writeback queue draining into a single regfile write port, with pending lookup.
// Optional: WB_EMPTY_BYPASS_EN sends the oldest accepted result straight to the port when empty.
import wb_pkg::*;

module wb_write_serializer #(
    parameter int DEPTH = WB_DEPTH,
    parameter int XLEN  = WB_XLEN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb0_valid,
    input  logic [4:0]            wb0_idx,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_valid,
    input  logic [4:0]            wb1_idx,
    input  logic [XLEN-1:0]       wb1_data,
    output logic                  wb_stall,
    output logic                  rf_write_en,
    output logic [4:0]            rf_write_idx,
    output logic [XLEN-1:0]       rf_write_data,
    input  logic [3:0][4:0]       lk_idx,
    output logic [3:0]            lk_hit,
    output logic [3:0][XLEN-1:0]  lk_data,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] q;
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count, nenq;
    logic                  raw0, raw1, acc0, acc1, enq0, enq1, pop;
    wb_entry_t             in0, in1;

    assign in0      = '{idx: wb0_idx, data: wb0_data};
    assign in1      = '{idx: wb1_idx, data: wb1_data};
    assign wb_stall = count > (PTR_W+1)'(DEPTH-2);
    assign empty    = count == '0;
    assign pop      = count != '0;

    assign raw0 = wb0_valid && wb0_idx != 5'd0 && !wb_stall;
    assign raw1 = wb1_valid && wb1_idx != 5'd0 && !wb_stall;
    assign acc1 = raw1;
    // Same destination in both lanes: the younger lane 1 result supersedes lane 0.
    assign acc0 = raw0 && !(raw1 && wb1_idx == wb0_idx);

    always_comb begin
        enq0          = acc0;
        enq1          = acc1;
        rf_write_en   = pop;
        rf_write_idx  = q[head].idx;
        rf_write_data = q[head].data;
`ifdef WB_EMPTY_BYPASS_EN
        if (!pop && (acc0 || acc1)) begin
            rf_write_en   = 1'b1;
            rf_write_idx  = acc0 ? wb0_idx : wb1_idx;
            rf_write_data = acc0 ? wb0_data : wb1_data;
            enq0          = 1'b0;
            enq1          = acc0 && acc1;
        end
`endif
    end

    assign nenq = (PTR_W+1)'(enq0) + (PTR_W+1)'(enq1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count - (PTR_W+1)'(pop) + nenq;
            head  <= head + PTR_W'(pop);
            tail  <= tail + nenq[PTR_W-1:0];
        end
    end

    // Payload storage is deliberately not reset; count alone says what is valid.
    always_ff @(posedge clock) begin
        if (enq0) q[tail] <= in0;
        if (enq1) q[enq0 ? tail + PTR_W'(1) : tail] <= in1;
    end

    for (genvar n = 0; n < 4; n++) begin : g_lk
        wb_pending_lookup #(.DEPTH(DEPTH)) u_lk (
            .idx   (lk_idx[n]),
            .q     (q),
            .head  (head),
            .count (count),
            .acc0  (acc0),
            .in0   (in0),
            .acc1  (acc1),
            .in1   (in1),
            .hit   (lk_hit[n]),
            .data  (lk_data[n])
        );
    end

    a_no_valid_when_stalled: assert property (
        @(posedge clock) disable iff (reset) wb_stall |-> !(wb0_valid || wb1_valid)
    ) else $error("wb_write_serializer: valid asserted while wb_stall");
endmodule

// File: tb/tb_wb_write_serializer.sv
// Directed self-checking bench for wb_write_serializer (DEPTH=4).
import wb_pkg::*;

module tb_wb_write_serializer;
    logic                     clock, reset;
    logic                     wb0_valid, wb1_valid;
    logic [4:0]               wb0_idx, wb1_idx;
    logic [WB_XLEN-1:0]       wb0_data, wb1_data;
    logic                     wb_stall, rf_write_en, empty;
    logic [4:0]               rf_write_idx;
    logic [WB_XLEN-1:0]       rf_write_data;
    logic [3:0][4:0]          lk_idx;
    logic [3:0]               lk_hit;
    logic [3:0][WB_XLEN-1:0]  lk_data;
    int                       errors = 0;
    int                       checks = 0;

    wb_write_serializer dut (
        .clock(clock), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_idx(wb0_idx), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_idx(wb1_idx), .wb1_data(wb1_data),
        .wb_stall(wb_stall), .rf_write_en(rf_write_en),
        .rf_write_idx(rf_write_idx), .rf_write_data(rf_write_data),
        .lk_idx(lk_idx), .lk_hit(lk_hit), .lk_data(lk_data), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [4:0] i, input logic [31:0] d);
        wb0_valid = 1'b1; wb0_idx = i; wb0_data = WB_XLEN'(d);
    endtask

    task automatic push1(input logic [4:0] i, input logic [31:0] d);
        wb1_valid = 1'b1; wb1_idx = i; wb1_data = WB_XLEN'(d);
    endtask

    // Advance one clock, sample 1 time unit after the edge, and drop lane valids.
    task automatic tick();
        @(posedge clock);
        #1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] i, input logic [31:0] d);
        chk({tag, "_en"}, 64'(rf_write_en), 64'd1);
        chk({tag, "_idx"}, 64'(rf_write_idx), 64'(i));
        chk({tag, "_data"}, 64'(rf_write_data), 64'(d));
    endtask

    initial begin
        reset = 1'b1;
        wb0_valid = 1'b0; wb0_idx = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_idx = '0; wb1_data = '0;
        lk_idx = '0;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_stall", 64'(wb_stall), 64'd0);
        chk("rst_wen", 64'(rf_write_en), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

`ifndef WB_EMPTY_BYPASS_EN
        // Single push, one-cycle latency.
        push0(5'd5, 32'h11);
        lk_idx[0] = 5'd5;
        #1;
        chk("t1_lk_hit", 64'(lk_hit[0]), 64'd1);
        chk("t1_lk_data", 64'(lk_data[0]), 64'h11);
        chk("t1_wen_same_cycle", 64'(rf_write_en), 64'd0);
        tick();
        chk_wr("t1_wr", 5'd5, 32'h11);
        chk("t1_empty_q", 64'(empty), 64'd0);
        tick();
        chk("t1_empty_after", 64'(empty), 64'd1);
        chk("t1_wen_after", 64'(rf_write_en), 64'd0);

        // Equal destinations: lane 0 dropped.
        push0(5'd7, 32'hA);
        push1(5'd7, 32'hB);
        lk_idx[0] = 5'd7;
        #1;
        chk("t2_lk_data", 64'(lk_data[0]), 64'hB);
        tick();
        chk_wr("t2_wr", 5'd7, 32'hB);
        tick();
        chk("t2_empty", 64'(empty), 64'd1);

        // Fill to stall, then drain in order.
        push0(5'd1, 32'h101);
        push1(5'd2, 32'h102);
        tick();
        chk_wr("t3_wr1", 5'd1, 32'h101);
        chk("t3_stall_c2", 64'(wb_stall), 64'd0);
        push0(5'd3, 32'h103);
        push1(5'd4, 32'h104);
        tick();
        chk_wr("t3_wr2", 5'd2, 32'h102);
        chk("t3_stall_c3", 64'(wb_stall), 64'd1);
        tick();
        chk_wr("t3_wr3", 5'd3, 32'h103);
        chk("t3_stall_drop", 64'(wb_stall), 64'd0);
        tick();
        chk_wr("t3_wr4", 5'd4, 32'h104);
        tick();
        chk("t3_empty", 64'(empty), 64'd1);

        // Build queue [x3=0x30, x3=0x31] with count 2.
        push0(5'd14, 32'hE0);
        tick();
        push0(5'd15, 32'hF0);
        push1(5'd3, 32'h30);
        tick();
        push0(5'd3, 32'h31);
        tick();
        chk_wr("t4_head", 5'd3, 32'h30);
        chk("t4_stall", 64'(wb_stall), 64'd0);
        lk_idx[0] = 5'd3; lk_idx[1] = 5'd15; lk_idx[2] = 5'd0; lk_idx[3] = 5'd20;
        #1;
        chk("t4_q_young", 64'(lk_data[0]), 64'h31);
        chk("t4_drained_miss", 64'(lk_hit[1]), 64'd0);
        chk("t4_x0_hit", 64'(lk_hit[2]), 64'd0);
        chk("t4_x0_data", 64'(lk_data[2]), 64'd0);
        chk("t4_nomatch_hit", 64'(lk_hit[3]), 64'd0);
        chk("t4_nomatch_data", 64'(lk_data[3]), 64'd0);
        push1(5'd3, 32'h32);
        #1;
        chk("t4_lane1_hit", 64'(lk_hit[0]), 64'd1);
        chk("t4_lane1_data", 64'(lk_data[0]), 64'h32);
        wb1_valid = 1'b0;
        push0(5'd3, 32'h33);
        #1;
        chk("t4_lane0_data", 64'(lk_data[0]), 64'h33);
        wb0_valid = 1'b0;
        #1;
        chk("t4_blocked_data", 64'(lk_data[0]), 64'h31);
        tick();
        chk_wr("t4_wr2", 5'd3, 32'h31);
        chk("t4_head_hit", 64'(lk_hit[0]), 64'd1);
        tick();
        chk("t4_empty", 64'(empty), 64'd1);
`else
        // Empty-queue bypass: same-cycle write, nothing enqueued.
        push0(5'd9, 32'h99);
        #1;
        chk_wr("t6_byp", 5'd9, 32'h99);
        tick();
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_wen_after", 64'(rf_write_en), 64'd0);
        push0(5'd9, 32'h90);
        push1(5'd10, 32'hA0);
        #1;
        chk_wr("t6_dual_byp", 5'd9, 32'h90);
        tick();
        chk_wr("t6_dual_q", 5'd10, 32'hA0);
        tick();
        chk("t6_dual_empty", 64'(empty), 64'd1);
`endif

        // x0 is never enqueued or written.
        push0(5'd0, 32'hFF);
        #1;
        chk("t5_x0_wen", 64'(rf_write_en), 64'd0);
        tick();
        chk("t5_x0_empty", 64'(empty), 64'd1);
        chk("t5_x0_wen_next", 64'(rf_write_en), 64'd0);

        // Async reset mid-drain discards everything immediately.
        push0(5'd1, 32'h1);
        push1(5'd2, 32'h2);
        tick();
        push0(5'd3, 32'h3);
        push1(5'd4, 32'h4);
        tick();
        chk("t5_pre_rst_wen", 64'(rf_write_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_wen", 64'(rf_write_en), 64'd0);
        chk("t5_rst_empty", 64'(empty), 64'd1);
        chk("t5_rst_stall", 64'(wb_stall), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        chk("t5_post_wen", 64'(rf_write_en), 64'd0);
        chk("t5_post_empty", 64'(empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_write_serializer.md
Name: wb_write_serializer

Overview:
- Writeback-side companion to the register file. It accepts up to two retiring results per cycle from the two superscalar lanes and buffers them in an in-order queue.
- It drains one result per cycle into the register file's single write port.
- It provides a 4-port pending-value lookup so ID-stage reads see results that are queued but not yet written.
- It backpressures the MEM/WB boundary when the queue cannot absorb two more results.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 4.
- XLEN, `XLEN from sys_defs.svh, data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wb0_valid  in  1  lane 0 (older) result valid
- wb0_idx  in  5  lane 0 destination register
- wb0_data  in  XLEN  lane 0 result
- wb1_valid  in  1  lane 1 (younger) result valid
- wb1_idx  in  5  lane 1 destination register
- wb1_data  in  XLEN  lane 1 result
- wb_stall  out  1  upstream must not assert wbN_valid while high
- rf_write_en  out  1  to regfile write_en
- rf_write_idx  out  5  to regfile write_idx
- rf_write_data  out  XLEN  to regfile write_data
- lk_idx[4]  in  4x5  lookup indices (same as regfile read_idx_1..4)
- lk_hit[4]  out  4x1  pending value exists for lk_idx[n]
- lk_data[4]  out  4xXLEN  youngest pending value for lk_idx[n]
- empty  out  1  queue holds no entries

Behaviour:
- Reset (async, active-high):
  - count=0, head=0, tail=0; empty=1, wb_stall=0, rf_write_en=0.
  - Entry payloads are not reset.
  - Reset mid-operation discards all pending entries.
- Enqueue filter:
  - A lane is accepted iff valid && idx!=0 && !wb_stall.
  - If both lanes are accepted with equal idx, lane 0 is dropped (lane 1 is younger).
  - Accepted entries are written at tail in order lane0, lane1; tail advances by 0/1/2 modulo DEPTH.
  - valid asserted while wb_stall=1 is a protocol violation: inputs are ignored, state unchanged (assertion in sim).
- Drain:
  - rf_write_en = (count!=0).
  - rf_write_idx/rf_write_data = entry[head], driven from flops.
  - head advances by 1 each cycle rf_write_en=1.
  - Minimum latency: an accepted result appears on the write port the cycle after acceptance.
- Count: count_next = count - drain + enq, with enq in {0,1,2}. Simultaneous drain and enqueue is legal.
- wb_stall = (count > DEPTH-2), computed from registered count. The queue therefore never overflows.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally; full and empty are distinguished by count, not by pointers.
- Lookup (combinational), per port n:
  - Priority, youngest first: accepted lane 1 input, then accepted lane 0 input, then queue entries from tail-1 back to head.
  - lk_hit=1 and lk_data = first match.
  - lk_idx=0 gives lk_hit=0, lk_data=0.
  - The head entry being drained this cycle still reports a hit; this is consistent with regfile internal forwarding.
  - No match gives lk_hit=0, lk_data=0.
- empty = (count==0).

Optional Feature:
- Macro: WB_EMPTY_BYPASS_EN.
- Defined: when count==0 and at least one lane is accepted, the oldest accepted entry drives rf_write_* combinationally in the same cycle (zero latency) and is not enqueued. The remaining lane, if any, is enqueued.
- Undefined: all results pass through the queue, with 1-cycle minimum latency.

Decomposition:
- Package wb_pkg:
  - wb_entry_t struct {logic [4:0] idx; logic [XLEN-1:0] data;}
  - WB_DEPTH constant
  - WB_PTR_W = $clog2(WB_DEPTH)
- Sub-module wb_pending_lookup:
  - One index in; queue array, head, count and the two accepted inputs in.
  - Outputs hit and data.
  - Instantiated 4 times.

Test Plan:
1. Reset, then single push: wb0 {x5, 0x11} -> next cycle rf_write_en=1, idx=5, data=0x11; the cycle after, empty=1.
2. Dual push with equal destination: wb0 {x7, 0xA}, wb1 {x7, 0xB} -> only 0xB is written to x7; count peaks at 1.
3. Fill and backpressure (DEPTH=4): two cycles of dual pushes to x1..x4 -> wb_stall=1 when count=3. The queue drains x1,x2,x3,x4 in order over 4 consecutive cycles; wb_stall drops when count<=2.
4. Lookup priority: queue holds x3=0x30 (old) and x3=0x31 (newer); wb1 pushes x3=0x32 -> lk_hit=1, lk_data=0x32 this cycle and 0x31 after the push is blocked. lk_idx=0 gives hit=0.
5. x0 filter plus async reset: push x0=0xFF gives no enqueue and no write. Asserting reset mid-drain with 3 entries gives rf_write_en=0 and empty=1 immediately, with no further writes.
6. WB_EMPTY_BYPASS_EN defined, queue empty: push wb0 {x9, 0x99} -> rf_write_en=1, idx=9 in the same cycle; count stays 0.
